// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-requester arbiter with registered one-hot grant, done/drop release and hold limit.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the highest requesting index wins.
module req_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_id_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);
  localparam int CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  typedef enum logic {S_IDLE, S_GRANT} state_e;
  state_e          state_q, state_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      id_q, id_d, win;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d, drop, lim;
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] last_q, last_d;
  // Later loop iterations override, so last_q-1 ends up with top priority and last_q with the lowest.
  always_comb begin
    win = '0;
    for (int p = 8; p >= 1; p--) if (req_i[last_q - 3'(p)]) win = last_q - 3'(p);
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < 8; i++) if (req_i[i]) win = 3'(i);
  end
`endif
  assign drop = done_i | ~req_i[id_q];
  assign lim  = (HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX - 1));
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    if (state_q == S_IDLE) begin
      if (|req_i) begin
        state_d = S_GRANT;
        gnt_d   = 8'd1 << win;
        id_d    = win;
        cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = win;
`endif
      end
    end else if (drop || lim) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      id_d    = '0;
      to_d    = ~drop;
    end else begin
      cnt_d   = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end
  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = (state_q == S_GRANT);
  assign timeout_o   = to_q;
endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_req_arbiter8;
  localparam int HM = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic        done;
  logic [7:0]  gnt;
  logic [2:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout;
  logic [12:0] obs;
  int          errs = 0;
  int          checks = 0;
  int          m_own = -1;
  int          m_held = 0;
  int          m_last = 0;
  bit          m_to = 1'b0;

  req_arbiter8 #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .gnt_valid_o(gnt_valid), .timeout_o(timeout)
  );

  always #5 clk = ~clk;
  assign obs = {gnt, gnt_id, gnt_valid, timeout};

  function automatic int pick(logic [7:0] r, int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int p = 1; p <= 8; p++) if (r[(last - p + 8) % 8]) return (last - p + 8) % 8;
`else
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
`endif
    return 0;
  endfunction

  // Reference model: owner index (-1 idle) and how many cycles it has already held the grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own = -1; m_held = 0; m_to = 1'b0; m_last = 0;
    end else if (m_own < 0) begin
      m_to = 1'b0;
      if (req != 8'h00) begin m_own = pick(req, m_last); m_held = 1; m_last = m_own; end
    end else if (done || !req[m_own]) begin
      m_own = -1;
    end else if (m_held == HM) begin
      m_own = -1; m_to = 1'b1;
    end else begin
      m_held++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'hFF; done = 1'b0;
    tick(3);
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL reset_state: got %h want %h", obs, 13'h0); end
    rst_n = 1'b1;
    tick();
    checks++; if (obs !== {8'h80, 3'd7, 2'b10}) begin errs++; $display("FAIL reset_first_grant: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    req = 8'h00;
    tick();
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL reset_drop_idle: got %h want %h", obs, 13'h0); end
  endtask

  task automatic test_done_drop();
    req = 8'b0010_0010; done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (obs !== {8'h20, 3'd5, 2'b10}) begin errs++; $display("FAIL done_hold_c%0d: got %h want %h", c, obs, {8'h20, 3'd5, 2'b10}); end
    end
    done = 1'b1; req = 8'h02;
    tick();
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL done_dead: got %h want %h", obs, 13'h0); end
    done = 1'b0;
    tick();
    checks++; if (obs !== {8'h02, 3'd1, 2'b10}) begin errs++; $display("FAIL done_next: got %h want %h", obs, {8'h02, 3'd1, 2'b10}); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    req = 8'h08; done = 1'b0;
    for (int c = 1; c <= HM; c++) begin
      tick();
      checks++; if (obs !== {8'h08, 3'd3, 2'b10}) begin errs++; $display("FAIL to_hold_c%0d: got %h want %h", c, obs, {8'h08, 3'd3, 2'b10}); end
    end
    tick();
    checks++; if (obs !== {8'h00, 3'd0, 2'b01}) begin errs++; $display("FAIL to_pulse: got %h want %h", obs, {8'h00, 3'd0, 2'b01}); end
    tick();
    checks++; if (obs !== {8'h08, 3'd3, 2'b10}) begin errs++; $display("FAIL to_regrant: got %h want %h", obs, {8'h08, 3'd3, 2'b10}); end
    tick(HM - 1);
    done = 1'b1;
    tick();
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL to_done_wins: got %h want %h", obs, 13'h0); end
    done = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_no_preempt();
    req = 8'h04; done = 1'b0;
    tick();
    checks++; if (obs !== {8'h04, 3'd2, 2'b10}) begin errs++; $display("FAIL np_grant: got %h want %h", obs, {8'h04, 3'd2, 2'b10}); end
    req = 8'h84;
    tick();
    checks++; if (obs !== {8'h04, 3'd2, 2'b10}) begin errs++; $display("FAIL np_hold: got %h want %h", obs, {8'h04, 3'd2, 2'b10}); end
    done = 1'b1;
    tick();
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL np_dead: got %h want %h", obs, 13'h0); end
    done = 1'b0;
    tick();
    checks++; if (obs !== {8'h80, 3'd7, 2'b10}) begin errs++; $display("FAIL np_next: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 8'hFF; done = 1'b1;
    for (int k = 0; k <= 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e = 3'((15 - k) % 8);
`else
      e = 3'd7;
`endif
      tick();
      checks++; if (obs !== {8'd1 << e, e, 2'b10}) begin errs++; $display("FAIL rr_seq%0d: got %h want %h", k, obs, {8'd1 << e, e, 2'b10}); end
      tick();
    end
    done = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    req = 8'h08; done = 1'b0;
    tick();
    checks++; if (obs !== {8'h08, 3'd3, 2'b10}) begin errs++; $display("FAIL ar_grant: got %h want %h", obs, {8'h08, 3'd3, 2'b10}); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (obs !== 13'h0) begin errs++; $display("FAIL ar_clear: got %h want %h", obs, 13'h0); end
    tick();
    rst_n = 1'b1; req = 8'hFF;
    tick();
    checks++; if (obs !== {8'h80, 3'd7, 2'b10}) begin errs++; $display("FAIL ar_ptr: got %h want %h", obs, {8'h80, 3'd7, 2'b10}); end
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [12:0] e;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) req = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(4) == 0);
      tick();
      e = (m_own < 0) ? {11'h0, 1'b0, m_to} : {8'd1 << m_own, 3'(m_own), 2'b10};
      checks++; if (obs !== e) begin errs++; $display("FAIL rand_cyc%0d: got %h want %h", n, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_done_drop();
    test_timeout();
    test_no_preempt();
    test_round_robin();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
